// File: rtl/nes_pkg.sv
// Shared types for the NES memory arbiter and the host command decoder.
//   arb_state_t : arbiter sequencing state
//   owner_t     : which master currently drives the memory port
//   host_cmd_t  : host command opcodes decoded upstream into cmd_* pulses
package nes_pkg;

  typedef enum logic [1:0] {
    HALT,
    CRST,
    RUN,
    STALL
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_HOST
  } owner_t;

  typedef enum logic [2:0] {
    HCMD_NOP,
    HCMD_RESET,
    HCMD_START,
    HCMD_STOP,
    HCMD_READ,
    HCMD_WRITE
  } host_cmd_t;

endpackage

// File: rtl/nes_mem_arbiter.sv
// Sequences the 6502 core and shares the single-port memory between the
// core and the host bus.
//   clk, reset                   : clock, synchronous active-high reset
//   cmd_reset/cmd_start/cmd_stop : single-cycle host commands
//   host_req/we/addr/wdata       : host access request, held until host_ack
//   host_ack/rdata/rvalid        : grant pulse, read data one cycle later
//   cpu_addr/write/dout, cpu_din : cpu bus
//   cpu_ready, cpu_reset         : cpu clock enable and reset
//   mem_addr/write/in, mem_out   : memory port (1-cycle read latency)
//   running                      : cpu is in RUN or STALL
module nes_mem_arbiter
  import nes_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int RESET_CYCLES = 8,
  parameter int CPU_SLICE    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_reset,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_ready,
  output logic              cpu_reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              running
);

  localparam int SLICE_W = $clog2(CPU_SLICE + 1);
  localparam int RST_W   = $clog2(RESET_CYCLES + 1);

  arb_state_t         state_q, state_d;
  owner_t             owner_q;
  logic [SLICE_W-1:0] slice_q, slice_inc;
  logic [RST_W-1:0]   rst_cnt_q;
  logic               cpu_reset_q;
  logic               stop_pend_q;
  logic               rd_vld_p1;
  logic [DATA_W-1:0]  rdata_hold;
  logic [DATA_W-1:0]  din_hold;

  function automatic logic [SLICE_W-1:0] slice_sat_inc(input logic [SLICE_W-1:0] v);
    if (v == SLICE_W'(CPU_SLICE)) return v;
    return v + SLICE_W'(1);
  endfunction

  assign slice_inc = slice_sat_inc(slice_q);

  // Grant decision. slice_inc is the ready-cycle count including the current
  // cycle, so a held request is granted right after CPU_SLICE ready cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HALT: begin
        if (cmd_reset)      state_d = CRST;
        else if (cmd_start) state_d = RUN;
      end
      CRST: begin
        if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) state_d = HALT;
      end
      RUN: begin
        if (cmd_reset)                                      state_d = CRST;
        else if (cmd_stop || stop_pend_q)                   state_d = HALT;
        else if (host_req && slice_inc == SLICE_W'(CPU_SLICE)) state_d = STALL;
      end
      STALL: begin
        if (cmd_reset) state_d = CRST;
        else           state_d = RUN;
      end
      default: state_d = HALT;
    endcase
  end

  // Host grants are combinational so a HALT access completes in one cycle.
  // reset gates every strobe so an access interrupted by reset never writes.
  always_comb begin
    host_ack = host_req && !reset && (state_q == HALT || state_q == STALL);
    if (owner_q == OWN_CPU) begin
      mem_addr  = cpu_addr;
      mem_in    = cpu_dout;
      mem_write = cpu_write && cpu_ready && !reset;
    end else begin
      mem_addr  = host_addr;
      mem_in    = host_wdata;
      mem_write = host_ack && host_we;
    end
  end

  assign cpu_ready   = (state_q == RUN);
  assign cpu_reset   = cpu_reset_q || (state_q == CRST);
  assign running     = (state_q == RUN) || (state_q == STALL);
  assign host_rvalid = rd_vld_p1 && !reset;
  assign host_rdata  = rd_vld_p1 ? mem_out : rdata_hold;
  // Outside RUN the cpu sees the last value it had, not host traffic.
  assign cpu_din     = (state_q == RUN) ? mem_out : din_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HALT;
      owner_q     <= OWN_HOST;
      slice_q     <= '0;
      rst_cnt_q   <= '0;
      cpu_reset_q <= 1'b1;
      stop_pend_q <= 1'b0;
      rd_vld_p1   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= (state_d == RUN) ? OWN_CPU : OWN_HOST;
      slice_q     <= (state_q == RUN) ? slice_inc : '0;
      rst_cnt_q   <= (state_q == CRST) ? rst_cnt_q + RST_W'(1) : '0;
      // Power-on cpu reset is held until the arbiter first leaves HALT.
      if (state_q != HALT) cpu_reset_q <= 1'b0;
      // A stop seen during a host slot is replayed on the next RUN cycle.
      stop_pend_q <= (state_q == STALL) && cmd_stop && !cmd_reset;
      rd_vld_p1   <= host_ack && !host_we;
    end
  end

  // ---- data capture stage (p1): no reset on data ----
  always_ff @(posedge clk) begin
    if (rd_vld_p1) rdata_hold <= mem_out;
    if (state_q == RUN) din_hold <= mem_out;
  end

endmodule

// File: tb/tb_nes_mem_arbiter.sv
module tb_nes_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset, cmd_reset, cmd_start, cmd_stop;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack, host_rvalid;
  logic [7:0]  host_rdata;
  logic [15:0] cpu_addr;
  logic        cpu_write;
  logic [7:0]  cpu_dout, cpu_din;
  logic        cpu_ready, cpu_reset;
  logic [15:0] mem_addr;
  logic        mem_write;
  logic [7:0]  mem_in, mem_out;
  logic        running;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nes_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .RESET_CYCLES(8), .CPU_SLICE(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_reset(cmd_reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_ready(cpu_ready), .cpu_reset(cpu_reset),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_in(mem_in), .mem_out(mem_out),
    .running(running)
  );

  // Memory model: registered read; 0x1234 is a fixed ROM byte 0x5C.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_in;
    mem_out <= (mem_addr == 16'h1234) ? 8'h5C : mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, a, w, nack, rdy, t;
    int acks [3];
    acks = '{0, 0, 0};
    reset = 1'b1; cmd_reset = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0; host_wdata = 8'h0;
    cpu_addr = 16'h1234; cpu_write = 1'b0; cpu_dout = 8'h77;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 1);
    check("rst_cpu_ready", 32'(cpu_ready), 0);
    check("rst_host_ack", 32'(host_ack), 0);
    check("rst_rvalid", 32'(host_rvalid), 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_running", 32'(running), 0);

    // HALT host write then read
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h8000; host_wdata = 8'hA9;
    @(negedge clk);
    check("halt_wr_ack", 32'(host_ack), 1);
    check("halt_wr_we", 32'(mem_write), 1);
    check("halt_wr_addr", 32'(mem_addr), 32'h8000);
    check("halt_wr_data", 32'(mem_in), 32'hA9);
    tick();
    host_we = 1'b0;
    @(negedge clk);
    check("halt_rd_ack", 32'(host_ack), 1);
    check("halt_rd_no_we", 32'(mem_write), 0);
    check("halt_rd_rvalid_early", 32'(host_rvalid), 0);
    tick();
    host_req = 1'b0;
    @(negedge clk);
    check("halt_rvalid", 32'(host_rvalid), 1);
    check("halt_rdata", 32'(host_rdata), 32'hA9);
    tick();
    @(negedge clk);
    check("halt_rvalid_pulse", 32'(host_rvalid), 0);
    check("halt_rdata_held", 32'(host_rdata), 32'hA9);

    // CPU reset command: 8 cycles of cpu_reset, host waits
    tick();
    cmd_reset = 1'b1;
    tick();
    cmd_reset = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h8000;
    n = 0; a = 0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (!cpu_reset) break;
      n++;
      if (host_ack) a++;
      tick();
      @(negedge clk);
    end
    check("crst_len", n, 8);
    check("crst_no_ack", a, 0);
    check("crst_done", 32'(cpu_reset), 0);
    check("crst_ack_after", 32'(host_ack), 1);
    tick();
    host_req = 1'b0;

    // Start; host request from first RUN cycle
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h8000;
    @(negedge clk);
    check("run_ready", 32'(cpu_ready), 1);
    check("run_running", 32'(running), 1);
    check("run_mem_addr", 32'(mem_addr), 32'h1234);
    w = 0;
    for (int i = 0; i < 10; i++) begin
      if (host_ack) break;
      tick();
      @(negedge clk);
      w++;
    end
    check("stall_wait", w, 4);
    check("stall_ready", 32'(cpu_ready), 0);
    check("stall_cpu_din", 32'(cpu_din), 32'h5C);
    check("stall_mem_addr", 32'(mem_addr), 32'h8000);
    tick();
    host_req = 1'b0;
    @(negedge clk);
    check("stall_rvalid", 32'(host_rvalid), 1);
    check("stall_rdata", 32'(host_rdata), 32'hA9);
    check("stall_back_run", 32'(cpu_ready), 1);

    // Continuous host requests while the cpu writes
    tick();
    cpu_write = 1'b1; host_req = 1'b1; host_we = 1'b0;
    nack = 0; rdy = 0; t = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (host_ack) begin
        if (nack < 3) acks[nack] = t;
        nack++;
        check("stall_no_cpu_write", 32'(mem_write), 0);
      end else if (cpu_ready && nack >= 1 && nack < 3) begin
        rdy++;
      end
      t++;
      tick();
      if (nack == 3) break;
    end
    host_req = 1'b0; cpu_write = 1'b0;
    check("cont_grants", nack, 3);
    check("cont_space1", acks[1] - acks[0], 5);
    check("cont_space2", acks[2] - acks[1], 5);
    check("cont_ready_cycles", rdy, 8);

    // Simultaneous commands
    cmd_stop = 1'b1; cmd_start = 1'b1;
    tick();
    cmd_stop = 1'b0; cmd_start = 1'b0;
    @(negedge clk);
    check("stop_start_halt", 32'(running), 0);
    check("stop_start_ready", 32'(cpu_ready), 0);
    tick();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    @(negedge clk);
    check("restart_running", 32'(running), 1);
    tick();
    cmd_reset = 1'b1; cmd_stop = 1'b1;
    tick();
    cmd_reset = 1'b0; cmd_stop = 1'b0;
    @(negedge clk);
    check("rst_stop_crst", 32'(cpu_reset), 1);
    check("rst_stop_running", 32'(running), 0);
    for (int i = 0; i < 20; i++) begin
      if (!cpu_reset) break;
      tick();
      @(negedge clk);
    end
    check("rst_stop_halt", 32'(cpu_reset), 0);

    // Stop during STALL is deferred to the following RUN cycle
    tick();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h8000;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (host_ack) break;
      tick();
      @(negedge clk);
    end
    check("latch_stall", 32'(host_ack), 1);
    cmd_stop = 1'b1;
    @(posedge clk);
    #1 cmd_stop = 1'b0; host_req = 1'b0;
    @(negedge clk);
    check("latch_run_running", 32'(running), 1);
    check("latch_run_ready", 32'(cpu_ready), 1);
    tick();
    @(negedge clk);
    check("latch_halt", 32'(running), 0);

    // Seed 0x9000 while halted
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h9000; host_wdata = 8'h11;
    @(negedge clk);
    check("seed_ack", 32'(host_ack), 1);
    tick();
    host_req = 1'b0;

    // Reset during a STALL host write
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 16'h9000; host_wdata = 8'h33;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (running && !cpu_ready) break;
      tick();
      @(negedge clk);
    end
    check("mid_stall", 32'(host_ack), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_no_write", 32'(mem_write), 0);
    check("mid_rst_no_ack", 32'(host_ack), 0);
    @(posedge clk);
    #1 reset = 1'b0; host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    check("mid_rst_cpu_reset", 32'(cpu_reset), 1);
    check("mid_rst_ready", 32'(cpu_ready), 0);
    check("mid_rst_ack", 32'(host_ack), 0);
    check("mid_rst_rvalid", 32'(host_rvalid), 0);
    check("mid_rst_mem_write", 32'(mem_write), 0);
    check("mid_rst_running", 32'(running), 0);
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h9000;
    @(negedge clk);
    check("mid_rst_rd_ack", 32'(host_ack), 1);
    tick();
    host_req = 1'b0;
    @(negedge clk);
    check("mid_rst_rvalid_rd", 32'(host_rvalid), 1);
    check("mid_rst_mem_kept", 32'(host_rdata), 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
